// File: rtl/keys_conditioner.sv
// rtl/keys_conditioner.sv - per-key synchroniser, debounce and press/release pulses (optional KEYS_AUTOREPEAT_EN)
module keys_conditioner #(
    parameter int KEYS_W          = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW_KEYS = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [KEYS_W-1:0] keys_raw_i,
    output logic [KEYS_W-1:0] keys_o,
    output logic [KEYS_W-1:0] press_o,
    output logic [KEYS_W-1:0] release_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [KEYS_W-1:0] keys_norm;
    logic [KEYS_W-1:0] sync1;
    logic [KEYS_W-1:0] sync2;
    logic [CW-1:0]     cnt [KEYS_W];
    logic [KEYS_W-1:0] accept;
    logic [KEYS_W-1:0] rise;
    logic [KEYS_W-1:0] fall;
    logic [KEYS_W-1:0] repeat_hit;

    // Normalise so that 1 always means pressed before synchronising.
    assign keys_norm = (ACTIVE_LOW_KEYS != 0) ? ~keys_raw_i : keys_raw_i;

    // Two-flop synchroniser per key; reset value is "released".
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys_norm;
            sync2 <= sync1;
        end
    end

    // A new level is accepted on the cycle its run reaches DEBOUNCE_CYCLES.
    always_comb begin
        accept = '0;
        for (int k = 0; k < KEYS_W; k++) begin
            accept[k] = (sync2[k] != keys_o[k]) && (cnt[k] == CNT_LAST);
        end
    end

    assign rise = accept & ~keys_o;
    assign fall = accept & keys_o;

    // Run-length counter: any return to the stable level restarts qualification.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < KEYS_W; k++) begin
            if (!rst_i) begin
                cnt[k] <= '0;
            end else if (sync2[k] == keys_o[k]) begin
                cnt[k] <= '0;
            end else if (accept[k]) begin
                cnt[k] <= '0;
            end else begin
                cnt[k] <= cnt[k] + CW'(1);
            end
        end
    end

`ifdef KEYS_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt [KEYS_W];

    // rcnt == 0 means idle; a repeat fires on the cycle rcnt would expire.
    always_comb begin
        repeat_hit = '0;
        for (int k = 0; k < KEYS_W; k++) begin
            repeat_hit[k] = keys_o[k] && !fall[k] && (rcnt[k] == RW'(1));
        end
    end

    // Repeat timer: armed by an accepted press, reloaded on each repeat, cleared on release.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < KEYS_W; k++) begin
            if (!rst_i) begin
                rcnt[k] <= '0;
            end else if (fall[k]) begin
                rcnt[k] <= '0;
            end else if (rise[k]) begin
                rcnt[k] <= RW'(REPEAT_DELAY);
            end else if (rcnt[k] == RW'(1)) begin
                rcnt[k] <= RW'(REPEAT_PERIOD);
            end else if (rcnt[k] != '0) begin
                rcnt[k] <= rcnt[k] - RW'(1);
            end
        end
    end
`else
    // Constant zero: the repeat timing parameters only matter when autorepeat is built in.
    assign repeat_hit = {KEYS_W{(REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0)}};
`endif

    // Stable level and pulses are all registered on the same edge so they stay aligned.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            keys_o    <= '0;
            press_o   <= '0;
            release_o <= '0;
        end else begin
            keys_o    <= keys_o ^ accept;
            press_o   <= rise | repeat_hit;
            release_o <= fall;
        end
    end

endmodule

// File: tb/tb_keys_conditioner.sv
// tb/tb_keys_conditioner.sv - randomized and directed bench for keys_conditioner against a history-window model
module tb_keys_conditioner;

    localparam int KW = 4;
    localparam int DB = 8;
    localparam int RD = 20;
    localparam int RP = 6;
`ifdef KEYS_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KW-1:0] raw;
    logic [KW-1:0] keys;
    logic [KW-1:0] press;
    logic [KW-1:0] rel;

    always #5 clk = ~clk;

    keys_conditioner #(
        .KEYS_W(KW),
        .DEBOUNCE_CYCLES(DB),
        .ACTIVE_LOW_KEYS(1),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .keys_raw_i(raw),
        .keys_o(keys),
        .press_o(press),
        .release_o(rel)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: a key flips when the last DB synchronised samples all differ from its level.
    logic [KW-1:0] hist [DB+1];
    logic [KW-1:0] m_keys, m_press, m_rel;
    int            held [KW];

    task automatic model_edge();
        logic [KW-1:0] nk, npv, nrv;
        bit            all_diff;
        if (!rst_n) begin
            for (int i = 0; i <= DB; i++) hist[i] = '0;
            m_keys = '0; m_press = '0; m_rel = '0;
            for (int k = 0; k < KW; k++) held[k] = 0;
        end else begin
            nk = m_keys; npv = '0; nrv = '0;
            for (int k = 0; k < KW; k++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (hist[j][k] == m_keys[k]) all_diff = 1'b0;
                if (all_diff) begin
                    nk[k] = ~m_keys[k];
                    if (nk[k]) begin npv[k] = 1'b1; held[k] = 0; end
                    else nrv[k] = 1'b1;
                end else if (m_keys[k]) begin
                    held[k]++;
                    if (AR && (held[k] == RD || (held[k] > RD && (held[k] - RD) % RP == 0)))
                        npv[k] = 1'b1;
                end
            end
            for (int i = DB; i >= 1; i--) hist[i] = hist[i-1];
            hist[0] = ~raw;
            m_keys = nk; m_press = npv; m_rel = nrv;
        end
    endtask

    int cyc, wk, rise_at, fall_at, np_cnt, nr_cnt;
    int ptimes[$];

    task automatic clear_watch(input int k);
        wk = k; cyc = 0; rise_at = -1; fall_at = -1; np_cnt = 0; nr_cnt = 0;
        ptimes.delete();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("keys", keys, m_keys);
        check("press", press, m_press);
        check("release", rel, m_rel);
        if (keys[wk] && rise_at < 0) rise_at = cyc;
        if (!keys[wk] && rise_at >= 0 && fall_at < 0) fall_at = cyc;
        if (press[wk]) begin np_cnt++; ptimes.push_back(cyc); end
        if (rel[wk]) nr_cnt++;
    endtask

    int t_all, tf, t_p, exp_t;
    int cd [KW];

    initial begin
        rst_n = 1'b0;
        raw   = '0;
        clear_watch(0);

        // Reset with every key held pressed
        repeat (3) begin
            step();
            check("rst_out", {20'd0, keys, press, rel}, 32'd0);
        end
        rst_n = 1'b1;
        clear_watch(0);
        t_all = -1;
        repeat (14) begin
            step();
            if (keys == 4'hF && t_all < 0) begin
                t_all = cyc;
                check("rst_press", press, 4'hF);
            end
        end
        check("rst_latency", t_all, 10);
        raw = 4'hF;
        repeat (14) step();

        // Clean press and release on key0
        raw = 4'b1110;
        clear_watch(0);
        repeat (14) step();
        check("clean_rise", rise_at, 10);
        check("clean_npress", np_cnt, 1);
        raw = 4'hF;
        clear_watch(0);
        repeat (14) step();
        check("clean_fall", fall_at, 10);
        check("clean_nrel", nr_cnt, 1);
        check("clean_nopress", np_cnt, 0);

        // Glitch of DB-1 cycles on key1
        clear_watch(1);
        raw[1] = 1'b0;
        repeat (7) step();
        raw[1] = 1'b1;
        repeat (14) step();
        check("glitch_level", rise_at, -1);
        check("glitch_press", np_cnt, 0);
        check("glitch_rel", nr_cnt, 0);

        // Bounce on key2
        clear_watch(2);
        raw[2] = 1'b0; repeat (3) step();
        raw[2] = 1'b1; repeat (3) step();
        raw[2] = 1'b0; repeat (3) step();
        raw[2] = 1'b1; repeat (3) step();
        raw[2] = 1'b0;
        tf = cyc;
        repeat (14) step();
        check("bounce_latency", rise_at - tf, 10);
        check("bounce_npress", np_cnt, 1);
        raw = 4'hF;
        repeat (14) step();

        // Simultaneous press on keys 0 and 3
        raw = 4'b0110;
        clear_watch(0);
        t_p = -1;
        repeat (14) begin
            step();
            if (press != '0 && t_p < 0) begin
                t_p = cyc;
                check("simul_press", press, 4'b1001);
            end
        end
        check("simul_time", t_p, 10);

        // Key1 press interrupted by reset at cnt=5
        raw = 4'b0100;
        clear_watch(1);
        repeat (7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rstmid_nopulse", np_cnt, 0);
        check("rstmid_nolevel", rise_at, -1);
        clear_watch(1);
        repeat (14) step();
        check("rstmid_requal", rise_at, 10);
        check("rstmid_npress", np_cnt, 1);
        raw = 4'hF;
        repeat (14) step();

        // Long hold on key0, release aligned with a repeat slot
        raw = 4'b1110;
        clear_watch(0);
        repeat (50) step();
        raw = 4'hF;
        repeat (16) step();
        check("hold_npress", ptimes.size(), AR ? 6 : 1);
        for (int i = 0; i < ptimes.size() && i < 6; i++) begin
            exp_t = (i == 0) ? 10 : 30 + RP * (i - 1);
            check("hold_ptime", ptimes[i], exp_t);
        end
        check("hold_fall", fall_at, 60);
        check("hold_nrel", nr_cnt, 1);

        // Randomised hold times with occasional reset
        for (int k = 0; k < KW; k++) cd[k] = $urandom_range(1, 14);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < KW; k++) begin
                cd[k]--;
                if (cd[k] <= 0) begin
                    raw[k] = ~raw[k];
                    cd[k]  = $urandom_range(1, 14);
                end
            end
            rst_n = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
